// File: rtl/ide_autoconfig_if.sv
// 68000-side Zorro II bus signals seen by the IDE autoconfig block.
// master = host/bus side, slave = the board's autoconfig logic.
interface ide_autoconfig_if;
    logic [23:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        RW;
    logic        CFGIN_n;
    logic [15:12] DIN;
    logic [15:12] DOUT;
    logic        DOE;
    logic        CFGOUT_n;

    modport master (
        output ADDR, AS_n, UDS_n, LDS_n, RW, CFGIN_n, DIN,
        input  DOUT, DOE, CFGOUT_n
    );

    modport slave (
        input  ADDR, AS_n, UDS_n, LDS_n, RW, CFGIN_n, DIN,
        output DOUT, DOE, CFGOUT_n
    );
endinterface

// File: rtl/ide_autoconfig.sv
// Zorro II autoconfig responder for a 128K IDE board at $E80000.
// Optional feature macro IDE_AUTOBOOT_ROM_EN: advertises a valid diag ROM vector.
module ide_autoconfig #(
    parameter logic [15:0] MANUF_ID = 16'h082C,
    parameter logic [7:0]  PROD_ID  = 8'h07,
    parameter logic [31:0] SERIAL   = 32'h0000_0001,
    parameter logic [15:0] DIAG_VEC = 16'h4000
) (
    input  logic              CLK,
    input  logic              RESET_n,
    ide_autoconfig_if.slave   bus,
    output logic              configured,
    output logic              ide_access,
    output logic [23:17]      base_addr
);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        CONF   = 2'd1,
        SHUTUP = 2'd2
    } state_t;

`ifdef IDE_AUTOBOOT_ROM_EN
    localparam logic [7:0] ER_TYPE = 8'hD2;
`else
    localparam logic [7:0] ER_TYPE = 8'hC2;
`endif

    localparam logic [5:0] IDX_BASE_HI = 6'h24;   // byte offset $48
    localparam logic [5:0] IDX_BASE_LO = 6'h25;   // byte offset $4A
    localparam logic [5:0] IDX_SHUTUP  = 6'h26;   // byte offset $4C

    state_t      state;
    state_t      state_nxt;
    logic        ac_sel;
    logic        wr_stb;
    logic        wr_lock;
    logic        doe_q;
    logic        cfgout_n_q;
    logic [5:0]  reg_idx;
    logic [3:0]  nib_raw;
    logic        unused_addr;

    // Raw (non-inverted) autoconfig ROM nibble for a register index.
    function automatic logic [3:0] rom_nibble(input logic [5:0] idx);
        logic [3:0] n;
        n = 4'h0;
        case (idx)
            6'd0:  n = ER_TYPE[7:4];
            6'd1:  n = ER_TYPE[3:0];
            6'd2:  n = PROD_ID[7:4];
            6'd3:  n = PROD_ID[3:0];
            6'd8:  n = MANUF_ID[15:12];
            6'd9:  n = MANUF_ID[11:8];
            6'd10: n = MANUF_ID[7:4];
            6'd11: n = MANUF_ID[3:0];
            6'd12: n = SERIAL[31:28];
            6'd13: n = SERIAL[27:24];
            6'd14: n = SERIAL[23:20];
            6'd15: n = SERIAL[19:16];
            6'd16: n = SERIAL[15:12];
            6'd17: n = SERIAL[11:8];
            6'd18: n = SERIAL[7:4];
            6'd19: n = SERIAL[3:0];
`ifdef IDE_AUTOBOOT_ROM_EN
            6'd20: n = DIAG_VEC[15:12];
            6'd21: n = DIAG_VEC[11:8];
            6'd22: n = DIAG_VEC[7:4];
            6'd23: n = DIAG_VEC[3:0];
`endif
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    assign reg_idx = bus.ADDR[6:1];
    assign ac_sel  = (state == UNCONF) && !bus.CFGIN_n && !bus.AS_n &&
                     (bus.ADDR[23:16] == 8'hE8);
    // Only the first qualifying edge of a bus cycle counts as the write.
    assign wr_stb  = ac_sel && !bus.RW && !bus.UDS_n && !wr_lock;

    assign nib_raw  = rom_nibble(reg_idx);
    assign bus.DOUT = (reg_idx <= 6'd1) ? nib_raw : ~nib_raw;
    assign bus.DOE      = doe_q;
    assign bus.CFGOUT_n = cfgout_n_q;

    assign configured = (state == CONF);
    assign ide_access = configured && !bus.AS_n && (bus.ADDR[23:17] == base_addr);

    assign unused_addr = &{1'b0, bus.ADDR[15:7]};

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= UNCONF;
        end else begin
            state <= state_nxt;
        end
    end

    // CONF and SHUTUP are terminal: ac_sel already excludes them.
    always_comb begin
        state_nxt = state;
        if (wr_stb) begin
            case (reg_idx)
                IDX_BASE_HI: state_nxt = CONF;
                IDX_SHUTUP:  state_nxt = SHUTUP;
                default:     state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            base_addr <= 7'h00;
        end else if (wr_stb) begin
            if (reg_idx == IDX_BASE_HI) begin
                base_addr[23:20] <= bus.DIN[15:12];
            end else if (reg_idx == IDX_BASE_LO) begin
                base_addr[19:17] <= bus.DIN[15:13];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            doe_q      <= 1'b0;
            wr_lock    <= 1'b0;
            cfgout_n_q <= 1'b1;
        end else begin
            if (bus.AS_n) begin
                doe_q   <= 1'b0;
                wr_lock <= 1'b0;
            end else begin
                if (ac_sel && bus.RW && (!bus.UDS_n || !bus.LDS_n)) begin
                    doe_q <= 1'b1;
                end
                if (wr_stb) begin
                    wr_lock <= 1'b1;
                end
            end
            // Pass the chain on only once the configuring cycle has ended.
            if ((state != UNCONF) && bus.AS_n) begin
                cfgout_n_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ide_autoconfig.sv
// Directed scoreboard bench for ide_autoconfig (default parameters).
// Expectations follow IDE_AUTOBOOT_ROM_EN if it is defined for the build.
module tb_ide_autoconfig;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        configured;
    logic        ide_access;
    logic [23:17] base_addr;

    ide_autoconfig_if bus ();

    ide_autoconfig dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .bus        (bus),
        .configured (configured),
        .ide_access (ide_access),
        .base_addr  (base_addr)
    );

    always #5 CLK = ~CLK;

`ifdef IDE_AUTOBOOT_ROM_EN
    localparam logic [3:0] EXP_TYPE_HI = 4'hD;
    localparam logic [3:0] EXP_DIAG_HI = 4'hB;
`else
    localparam logic [3:0] EXP_TYPE_HI = 4'hC;
    localparam logic [3:0] EXP_DIAG_HI = 4'hF;
`endif

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h required=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h required=%0h", t, obs, e);
            end
        end
    endtask

    task automatic idle_bus();
        bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW = 1'b1;
    endtask

    task automatic do_read(input logic [23:0] a, output logic [3:0] d,
                           output logic doe_pre, output logic doe_on);
        @(negedge CLK);
        bus.ADDR = a[23:1]; bus.RW = 1'b1;
        bus.AS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b0;
        #1 doe_pre = bus.DOE; d = bus.DOUT;
        @(posedge CLK);
        #1 doe_on = bus.DOE;
        @(negedge CLK);
        idle_bus();
        @(posedge CLK);
        #1;
    endtask

    // DIN is flipped after the first edge so a missing write lock shows up.
    task automatic do_write(input logic [23:0] a, input logic [3:0] nib,
                            output logic cfg_mid, output logic conf_mid);
        @(negedge CLK);
        bus.ADDR = a[23:1]; bus.RW = 1'b0; bus.DIN = nib;
        bus.AS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b1;
        @(posedge CLK);
        #1 bus.DIN = ~nib; cfg_mid = bus.CFGOUT_n; conf_mid = configured;
        @(posedge CLK);
        @(negedge CLK);
        idle_bus();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] d;
    logic doe_pre, doe_on, cfg_mid, conf_mid;

    initial begin
        bus.ADDR = '0; bus.DIN = 4'h0; bus.CFGIN_n = 1'b0;
        idle_bus();
        repeat (3) @(posedge CLK);
        #1;
        expect_val("rst_configured", 0);  check(configured);
        expect_val("rst_cfgout_n", 1);    check(bus.CFGOUT_n);
        expect_val("rst_doe", 0);         check(bus.DOE);
        expect_val("rst_base", 0);        check(base_addr);
        @(negedge CLK) RESET_n = 1'b1;

        expect_val("rd00_dout", EXP_TYPE_HI); expect_val("rd00_doe_pre", 0);
        expect_val("rd00_doe", 1);        expect_val("rd00_doe_end", 0);
        do_read(24'hE80000, d, doe_pre, doe_on);
        check(d); check(doe_pre); check(doe_on); check(bus.DOE);

        expect_val("rd02_dout", 4'h2);    do_read(24'hE80002, d, doe_pre, doe_on); check(d);
        expect_val("rd04_dout", 4'hF);    do_read(24'hE80004, d, doe_pre, doe_on); check(d);
        expect_val("rd06_dout", 4'h8);    do_read(24'hE80006, d, doe_pre, doe_on); check(d);
        expect_val("rd12_dout", 4'h7);    do_read(24'hE80012, d, doe_pre, doe_on); check(d);
        expect_val("rd14_dout", 4'hD);    do_read(24'hE80014, d, doe_pre, doe_on); check(d);
        expect_val("rd16_dout", 4'h3);    do_read(24'hE80016, d, doe_pre, doe_on); check(d);
        expect_val("rd18_dout", 4'hF);    do_read(24'hE80018, d, doe_pre, doe_on); check(d);
        expect_val("rd26_dout", 4'hE);    do_read(24'hE80026, d, doe_pre, doe_on); check(d);
        expect_val("rd28_dout", EXP_DIAG_HI); do_read(24'hE80028, d, doe_pre, doe_on); check(d);
        expect_val("rd40_dout", 4'hF);    do_read(24'hE80040, d, doe_pre, doe_on); check(d);

        // Chain input high: board must stay off the bus.
        bus.CFGIN_n = 1'b1;
        expect_val("cfgin_hi_doe", 0);    do_read(24'hE80000, d, doe_pre, doe_on); check(doe_on);
        expect_val("cfgin_hi_wr48", 0);   do_write(24'hE80048, 4'hE, cfg_mid, conf_mid); check(configured);
        bus.CFGIN_n = 1'b0;

        expect_val("wr4a_base", 7'h00);   expect_val("wr4a_conf", 0);
        do_write(24'hE8004A, 4'h0, cfg_mid, conf_mid);
        check(base_addr); check(configured);

        expect_val("wr48_conf_mid", 1);   expect_val("wr48_cfgout_mid", 1);
        expect_val("wr48_base", 7'h70);   expect_val("wr48_cfgout_end", 0);
        do_write(24'hE80048, 4'hE, cfg_mid, conf_mid);
        check(conf_mid); check(cfg_mid); check(base_addr); check(bus.CFGOUT_n);

        expect_val("conf_rd_doe", 0);     do_read(24'hE80000, d, doe_pre, doe_on); check(doe_on);

        @(negedge CLK);
        bus.ADDR = 24'hE20000 >> 1; bus.AS_n = 1'b0;
        #1 expect_val("access_e2", 0);    check(ide_access);
        @(negedge CLK);
        bus.ADDR = 24'hE10000 >> 1;
        #1 expect_val("access_e1", 1);    check(ide_access);

        // Asynchronous reset in the middle of a hit.
        #2 RESET_n = 1'b0;
        #1 expect_val("arst_configured", 0); check(configured);
        expect_val("arst_cfgout_n", 1);   check(bus.CFGOUT_n);
        expect_val("arst_access", 0);     check(ide_access);
        expect_val("arst_base", 0);       check(base_addr);
        idle_bus();
        @(negedge CLK) RESET_n = 1'b1;

        expect_val("wr4c_conf", 0);       expect_val("wr4c_cfgout", 0);
        do_write(24'hE8004C, 4'h0, cfg_mid, conf_mid);
        check(configured); check(bus.CFGOUT_n);

        expect_val("shut_wr48_conf", 0);  expect_val("shut_wr48_base", 0);
        do_write(24'hE80048, 4'hE, cfg_mid, conf_mid);
        check(configured); check(base_addr);

        expect_val("shut_rd_doe", 0);     do_read(24'hE80000, d, doe_pre, doe_on); check(doe_on);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
